bus_to_bb_bridge: RTL and testbench

Responder-side bridge that accepts single-beat read/write requests from the system bus, decodes the 16-bit bus address back into the 12-bit bulletin-board (BB) address space, and executes the access on the BB port. It sits between a bus slave port and the BB memory, and is the inverse of the BB-to-bus address mapping used on the initiator side. The bridge rejects addresses outside the BB window and bounds each BB access with a timeout. Every request produces exactly one response.

---
 rtl/bus_to_bb_bridge_pkg.sv | 18 +
 rtl/bus_addr_decode.sv | 21 ++
 rtl/bus_to_bb_bridge.sv | 130 +++++++++++++
 tb/tb_bus_to_bb_bridge.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_to_bb_bridge_pkg.sv
// rtl/bus_to_bb_bridge_pkg.sv - shared state encodings and default widths for the bus-to-BB bridge
package bus_to_bb_bridge_pkg;

  localparam int BB_ADDR_W      = 12;
  localparam int BUS_ADDR_W     = 16;
  localparam int BUS_MEM_ADDR_W = 12;
  localparam int DATA_W         = 8;
  localparam int TIMEOUT_DEF    = 255;
  // Wide enough for any TIMEOUT in 1..255
  localparam int CNT_W          = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/bus_addr_decode.sv
// rtl/bus_addr_decode.sv - inverse mapping of a bus address into the BB window plus legality check
module bus_addr_decode
  import bus_to_bb_bridge_pkg::*;
#(
  parameter int BB_ADDR_WIDTH      = BB_ADDR_W,
  parameter int BUS_ADDR_WIDTH     = BUS_ADDR_W,
  parameter int BUS_MEM_ADDR_WIDTH = BUS_MEM_ADDR_W
) (
  input  logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  output logic [BB_ADDR_WIDTH-1:0]  bb_addr,
  output logic                      legal
);

  // Bank-select bit lives at BUS_MEM_ADDR_WIDTH on the bus, at the BB MSB on the memory side
  assign bb_addr = {bus_addr[BUS_MEM_ADDR_WIDTH], bus_addr[BB_ADDR_WIDTH-2:0]};

  // Anything above the bank bit, or in the gap between the offset and the bank bit, is outside the window
  assign legal = (bus_addr[BUS_ADDR_WIDTH-1:BUS_MEM_ADDR_WIDTH+1] == '0) &&
                 (bus_addr[BUS_MEM_ADDR_WIDTH-1:BB_ADDR_WIDTH-1] == '0);

endmodule

// File: rtl/bus_to_bb_bridge.sv
// rtl/bus_to_bb_bridge.sv - single-outstanding bus responder executing accesses on the BB port
module bus_to_bb_bridge
  import bus_to_bb_bridge_pkg::*;
#(
  parameter int BB_ADDR_WIDTH      = BB_ADDR_W,
  parameter int BUS_ADDR_WIDTH     = BUS_ADDR_W,
  parameter int BUS_MEM_ADDR_WIDTH = BUS_MEM_ADDR_W,
  parameter int DATA_WIDTH         = DATA_W,
  parameter int TIMEOUT            = TIMEOUT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bus_req_valid,
  output logic                      bus_req_ready,
  input  logic [BUS_ADDR_WIDTH-1:0] bus_addr,
  input  logic                      bus_wen,
  input  logic [DATA_WIDTH-1:0]     bus_wdata,
  output logic                      bus_rsp_valid,
  input  logic                      bus_rsp_ready,
  output logic [DATA_WIDTH-1:0]     bus_rdata,
  output logic                      bus_err,
  output logic                      bb_valid,
  output logic [BB_ADDR_WIDTH-1:0]  bb_addr,
  output logic                      bb_wen,
  output logic [DATA_WIDTH-1:0]     bb_wdata,
  input  logic                      bb_ack,
  input  logic [DATA_WIDTH-1:0]     bb_rdata
);

  // Last counter value before the access is abandoned; bb_valid is then high for TIMEOUT cycles
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                    state_q, state_d;
  logic [BB_ADDR_WIDTH-1:0]  addr_q;
  logic                      wen_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [DATA_WIDTH-1:0]     rdata_q;
  logic                      err_q;
  logic [CNT_W-1:0]          cnt_q;

  logic [BB_ADDR_WIDTH-1:0]  dec_addr;
  logic                      dec_legal;
  logic                      accept;
  logic                      timeout_hit;

  bus_addr_decode #(
    .BB_ADDR_WIDTH      (BB_ADDR_WIDTH),
    .BUS_ADDR_WIDTH     (BUS_ADDR_WIDTH),
    .BUS_MEM_ADDR_WIDTH (BUS_MEM_ADDR_WIDTH)
  ) u_decode (
    .bus_addr (bus_addr),
    .bb_addr  (dec_addr),
    .legal    (dec_legal)
  );

  assign accept      = bus_req_valid && bus_req_ready;
  // An ack in the final cycle takes priority over the timeout
  assign timeout_hit = (cnt_q == CNT_LAST) && !bb_ack;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: decode misses skip the BB access entirely
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)                 state_d = dec_legal ? ST_WAIT : ST_RESP;
      ST_WAIT: if (bb_ack || timeout_hit)  state_d = ST_RESP;
      ST_RESP: if (bus_rsp_ready)          state_d = ST_IDLE;
      default:                             state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; ready is held low while reset is applied
  always_comb begin
    bus_req_ready = (state_q == ST_IDLE) && !rst;
    bb_valid      = (state_q == ST_WAIT);
    bus_rsp_valid = (state_q == ST_RESP);
  end

  // Request capture, timeout counter and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= dec_addr;
            wen_q   <= bus_wen;
            wdata_q <= bus_wdata;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= !dec_legal;
          end
        end
        ST_WAIT: begin
          if (bb_ack) begin
            rdata_q <= wen_q ? '0 : bb_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bb_addr   = addr_q;
  assign bb_wen    = wen_q;
  assign bb_wdata  = wdata_q;
  assign bus_rdata = rdata_q;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_bus_to_bb_bridge.sv
// tb/tb_bus_to_bb_bridge.sv - scoreboard bench for bus_to_bb_bridge
module tb_bus_to_bb_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [15:0] bus_addr;
  logic        bus_wen;
  logic [7:0]  bus_wdata;
  logic        bus_rsp_valid;
  logic        bus_rsp_ready;
  logic [7:0]  bus_rdata;
  logic        bus_err;
  logic        bb_valid;
  logic [11:0] bb_addr;
  logic        bb_wen;
  logic [7:0]  bb_wdata;
  logic        bb_ack;
  logic [7:0]  bb_rdata;

  int total = 0;
  int bad   = 0;

  // expected responses as {err, rdata}
  logic [8:0] sb[$];
  logic [8:0] mon_e;

  always #5 clk = ~clk;

  bus_to_bb_bridge #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus_req_valid (bus_req_valid),
    .bus_req_ready (bus_req_ready),
    .bus_addr      (bus_addr),
    .bus_wen       (bus_wen),
    .bus_wdata     (bus_wdata),
    .bus_rsp_valid (bus_rsp_valid),
    .bus_rsp_ready (bus_rsp_ready),
    .bus_rdata     (bus_rdata),
    .bus_err       (bus_err),
    .bb_valid      (bb_valid),
    .bb_addr       (bb_addr),
    .bb_wen        (bb_wen),
    .bb_wdata      (bb_wdata),
    .bb_ack        (bb_ack),
    .bb_rdata      (bb_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // response monitor: pop and compare on every response handshake
  always @(negedge clk) begin
    if (!rst && bus_rsp_valid && bus_rsp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_rdata", {24'd0, bus_rdata}, {24'd0, mon_e[7:0]});
        chk("rsp_err", {31'd0, bus_err}, {31'd0, mon_e[8]});
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge; returns at the negedge where bus_rsp_valid is first seen.
  // ack_at: WAIT cycle number (1-based) to pulse bb_ack; 0 means never.
  task automatic do_req(input logic [15:0] a, input logic w, input logic [7:0] wd,
                        input int ack_at, input logic [7:0] brd);
    logic        legal;
    logic [11:0] ea;
    logic [8:0]  exp_rsp;
    int          exp_lat, exp_vcnt, vcnt, lat;
    legal = (a[15:13] == 3'b000) && !a[11];
    ea    = {a[12], a[10:0]};
    if (!legal) begin
      exp_rsp = 9'h100; exp_lat = 1; exp_vcnt = 0;
    end else if (ack_at >= 1 && ack_at <= TO) begin
      exp_rsp = {1'b0, (w ? 8'h00 : brd)}; exp_lat = ack_at + 1; exp_vcnt = ack_at;
    end else begin
      exp_rsp = 9'h100; exp_lat = TO + 1; exp_vcnt = TO;
    end
    sb.push_back(exp_rsp);
    bus_req_valid = 1'b1;
    bus_addr      = a;
    bus_wen       = w;
    bus_wdata     = wd;
    bb_rdata      = brd;
    @(negedge clk);
    chk("req_ready", {31'd0, bus_req_ready}, 32'd1);
    vcnt = 0;
    lat  = -1;
    for (int k = 1; k <= TO + 8; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) bus_req_valid = 1'b0;
      bb_ack = (k == ack_at);
      @(negedge clk);
      if (bb_valid) begin
        vcnt++;
        chk("bb_addr", {20'd0, bb_addr}, {20'd0, ea});
        chk("bb_wen", {31'd0, bb_wen}, {31'd0, w});
        chk("bb_wdata", {24'd0, bb_wdata}, {24'd0, wd});
      end
      if (bus_rsp_valid) begin
        lat = k;
        break;
      end
    end
    bb_ack = 1'b0;
    chk("latency", lat, exp_lat);
    chk("bb_valid_cycles", vcnt, exp_vcnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra;
    rst           = 1'b1;
    bus_req_valid = 1'b0;
    bus_addr      = '0;
    bus_wen       = 1'b0;
    bus_wdata     = '0;
    bus_rsp_ready = 1'b1;
    bb_ack        = 1'b0;
    bb_rdata      = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus_req_ready}, 32'd0);
    chk("rst_bb_valid", {31'd0, bb_valid}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus_rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, bus_rdata}, 32'd0);
    chk("rst_err", {31'd0, bus_err}, 32'd0);
    chk("rst_bb_addr", {20'd0, bb_addr}, 32'd0);
    next_cyc();
    rst = 1'b0;
    next_cyc();

    // legal read, ack in first WAIT cycle
    do_req(16'h1234, 1'b0, 8'h00, 1, 8'h5A);
    chk("map_0x1234", {20'd0, bb_addr}, 32'hA34);
    next_cyc();
    // legal write, ack in third WAIT cycle; read data from BB must be dropped
    do_req(16'h0010, 1'b1, 8'hC3, 3, 8'hEE);
    next_cyc();
    // decode misses, with a stray ack that must be ignored
    do_req(16'h0800, 1'b0, 8'h00, 1, 8'h11);
    next_cyc();
    do_req(16'h2000, 1'b1, 8'h22, 0, 8'h11);
    next_cyc();
    // timeout, then ack in the final allowed cycle
    do_req(16'h0123, 1'b0, 8'h00, 0, 8'h33);
    next_cyc();
    do_req(16'h1FF, 1'b0, 8'h00, TO, 8'h44);
    next_cyc();

    // backpressure
    bus_rsp_ready = 1'b0;
    do_req(16'h1001, 1'b0, 8'h00, 2, 8'h77);
    bus_req_valid = 1'b1;
    bus_addr      = 16'h0042;
    bus_wen       = 1'b0;
    bus_wdata     = 8'h00;
    for (int i = 0; i < 5; i++) begin
      next_cyc();
      @(negedge clk);
      chk("bp_rsp_valid", {31'd0, bus_rsp_valid}, 32'd1);
      chk("bp_rdata", {24'd0, bus_rdata}, 32'h77);
      chk("bp_err", {31'd0, bus_err}, 32'd0);
      chk("bp_req_ready", {31'd0, bus_req_ready}, 32'd0);
      chk("bp_bb_valid", {31'd0, bb_valid}, 32'd0);
    end
    next_cyc();
    bus_rsp_ready = 1'b1;
    next_cyc();
    do_req(16'h0042, 1'b0, 8'h00, 1, 8'h99);
    next_cyc();

    // reset while the BB access is pending
    bus_req_valid = 1'b1;
    bus_addr      = 16'h1555;
    bus_wen       = 1'b1;
    bus_wdata     = 8'hAB;
    next_cyc();
    bus_req_valid = 1'b0;
    @(negedge clk);
    chk("mid_bb_valid", {31'd0, bb_valid}, 32'd1);
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {31'd0, bus_req_ready}, 32'd0);
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_bb_valid", {31'd0, bb_valid}, 32'd0);
    chk("post_rst_rsp_valid", {31'd0, bus_rsp_valid}, 32'd0);
    chk("post_rst_bb_addr", {20'd0, bb_addr}, 32'd0);
    chk("post_rst_bb_wen", {31'd0, bb_wen}, 32'd0);
    chk("post_rst_bb_wdata", {24'd0, bb_wdata}, 32'd0);
    chk("post_rst_rdata", {24'd0, bus_rdata}, 32'd0);
    chk("post_rst_err", {31'd0, bus_err}, 32'd0);
    chk("post_rst_ready", {31'd0, bus_req_ready}, 32'd1);
    next_cyc();
    do_req(16'h1555, 1'b0, 8'h00, 2, 8'h3C);
    next_cyc();

    // random mix of legal/illegal addresses and ack timings
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 3) != 0) ra = ra & 16'h17FF;
      do_req(ra, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 5)), 8'($urandom_range(0, 255)));
      next_cyc();
    end

    repeat (2) next_cyc();
    chk("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
